// File: rtl/sqrt_task_scheduler.sv
// rtl/sqrt_task_scheduler.sv - in-order dispatcher/collector for a pool of external sqrt-formula workers
// Optional SQRT_SCHED_STATS_EN adds the saturating stall_cnt output.
module sqrt_task_scheduler #(
    parameter int N_WORKERS = 4,
    parameter int W         = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arg_vld,
    output logic                   arg_rdy,
    input  logic [W-1:0]           a,
    input  logic [W-1:0]           b,
    input  logic [W-1:0]           c,
    output logic                   res_vld,
    input  logic                   res_rdy,
    output logic [W-1:0]           res,
    output logic [N_WORKERS-1:0]   wrk_arg_vld,
    output logic [N_WORKERS*W-1:0] wrk_a,
    output logic [N_WORKERS*W-1:0] wrk_b,
    output logic [N_WORKERS*W-1:0] wrk_c,
    input  logic [N_WORKERS-1:0]   wrk_res_vld,
    input  logic [N_WORKERS*W-1:0] wrk_res,
    output logic                   err
`ifdef SQRT_SCHED_STATS_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    localparam int PW = (N_WORKERS > 1) ? $clog2(N_WORKERS) : 1;
    localparam logic [PW-1:0] LAST = PW'(N_WORKERS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    r_state [N_WORKERS];
    logic [W-1:0]  r_hold  [N_WORKERS];
    logic [PW-1:0] r_dp;
    logic [PW-1:0] r_cp;
    logic          r_err;
    logic          w_accept;
    logic          w_take;

    assign arg_rdy  = (r_state[r_dp] == IDLE);
    assign w_accept = arg_vld && arg_rdy;
    assign res_vld  = (r_state[r_cp] == DONE);
    assign w_take   = res_vld && res_rdy;
    assign res      = r_hold[r_cp];
    assign err      = r_err;

    // Accept, return and output handshake always target distinct workers in one
    // cycle (IDLE / BUSY / DONE respectively), so the writes below never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp        <= '0;
            r_cp        <= '0;
            r_err       <= 1'b0;
            wrk_arg_vld <= '0;
            for (int i = 0; i < N_WORKERS; i++) begin
                r_state[i] <= IDLE;
            end
        end else begin
            wrk_arg_vld <= '0;
            for (int i = 0; i < N_WORKERS; i++) begin
                if (wrk_res_vld[i]) begin
                    if (r_state[i] == BUSY) begin
                        r_state[i] <= DONE;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
            end
            if (w_take) begin
                r_state[r_cp] <= IDLE;
                r_cp          <= (r_cp == LAST) ? '0 : r_cp + 1'b1;
            end
            if (w_accept) begin
                r_state[r_dp]     <= BUSY;
                wrk_arg_vld[r_dp] <= 1'b1;
                r_dp              <= (r_dp == LAST) ? '0 : r_dp + 1'b1;
            end
        end
    end

    // Data registers carry no reset; they are only meaningful behind state.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            wrk_a[r_dp*W +: W] <= a;
            wrk_b[r_dp*W +: W] <= b;
            wrk_c[r_dp*W +: W] <= c;
        end
        for (int i = 0; i < N_WORKERS; i++) begin
            if (wrk_res_vld[i] && (r_state[i] == BUSY)) begin
                r_hold[i] <= wrk_res[i*W +: W];
            end
        end
    end

`ifdef SQRT_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (arg_vld && !arg_rdy && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sqrt_task_scheduler.sv
// tb/tb_sqrt_task_scheduler.sv - directed bench for sqrt_task_scheduler with behavioural latency workers
module tb_sqrt_task_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           arg_vld = 1'b0;
    logic           arg_rdy;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [W-1:0]   c = '0;
    logic           res_vld;
    logic           res_rdy = 1'b1;
    logic [W-1:0]   res;
    logic [N-1:0]   wrk_arg_vld;
    logic [N*W-1:0] wrk_a;
    logic [N*W-1:0] wrk_b;
    logic [N*W-1:0] wrk_c;
    logic [N-1:0]   wrk_res_vld;
    logic [N*W-1:0] wrk_res;
    logic           err;
`ifdef SQRT_SCHED_STATS_EN
    logic [31:0]    stall_cnt;
`endif

    sqrt_task_scheduler #(.N_WORKERS(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .arg_vld(arg_vld), .arg_rdy(arg_rdy), .a(a), .b(b), .c(c),
        .res_vld(res_vld), .res_rdy(res_rdy), .res(res),
        .wrk_arg_vld(wrk_arg_vld), .wrk_a(wrk_a), .wrk_b(wrk_b), .wrk_c(wrk_c),
        .wrk_res_vld(wrk_res_vld), .wrk_res(wrk_res), .err(err)
`ifdef SQRT_SCHED_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural workers: result = a + 2b + 3c, L cycles from start pulse to result pulse.
    int           lat [N];
    int           cnt [N];
    logic [W-1:0] m_val [N];
    logic [N-1:0] m_vld;
    logic [N-1:0] spur = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                m_vld[i] <= 1'b0;
                if (wrk_arg_vld[i]) begin
                    m_val[i] <= wrk_a[i*W +: W] + 2 * wrk_b[i*W +: W] + 3 * wrk_c[i*W +: W];
                    if (lat[i] <= 1) m_vld[i] <= 1'b1;
                    else cnt[i] <= lat[i] - 1;
                end else if (cnt[i] > 0) begin
                    cnt[i] <= cnt[i] - 1;
                    if (cnt[i] == 1) m_vld[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        wrk_res = '0;
        for (int i = 0; i < N; i++) wrk_res[i*W +: W] = m_val[i];
    end
    assign wrk_res_vld = m_vld | spur;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int base = 0;
    int n_tot, n_in, n_out, ord_err, stalls, first_stall;
    int acc_cyc [32];
    int out_cyc [32];
    int out_cp  [32];

    function automatic logic [W-1:0] ta(input int i); return W'(i + base + 1); endfunction
    function automatic logic [W-1:0] tb(input int i); return W'(2 * i + base + 3); endfunction
    function automatic logic [W-1:0] tc(input int i); return W'(3 * i + base + 7); endfunction
    function automatic logic [W-1:0] exp_of(input int i);
        return ta(i) + 2 * tb(i) + 3 * tc(i);
    endfunction

    task automatic clear_stats(input int total);
        n_tot = total; n_in = 0; n_out = 0; ord_err = 0; stalls = 0; first_stall = -1;
    endtask

    // One cycle: offer the next triplet, account for stalls/accepts/outputs, advance.
    task automatic step();
        if (n_in < n_tot) begin
            arg_vld = 1'b1; a = ta(n_in); b = tb(n_in); c = tc(n_in);
        end else begin
            arg_vld = 1'b0;
        end
        if (arg_vld && !arg_rdy) begin
            if (stalls == 0) first_stall = n_in;
            stalls++;
        end
        if (arg_vld && arg_rdy) begin
            acc_cyc[n_in] = cyc;
            n_in++;
        end
        if (res_vld && res_rdy) begin
            if (res !== exp_of(n_out)) ord_err++;
            out_cyc[n_out] = cyc;
            out_cp[n_out]  = int'(dut.r_cp);
            n_out++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; arg_vld = 1'b0; res_rdy = 1'b1; spur = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int c0, bad, unstable, rdy_bad;
    logic [W-1:0] r0;

    initial begin
        for (int i = 0; i < N; i++) lat[i] = 5;

        // Single triplet (3,4,5) after reset
        do_reset();
        check("rst_arg_rdy", arg_rdy, 1);
        check("rst_res_vld", res_vld, 0);
        check("rst_err", err, 0);
        check("rst_wrk_arg_vld", wrk_arg_vld, 0);
        arg_vld = 1'b1; a = 3; b = 4; c = 5; c0 = cyc;
        @(negedge clk);
        arg_vld = 1'b0;
        check("t1_pulse_cycle", cyc - c0, 1);
        check("t1_pulse", wrk_arg_vld, 4'b0001);
        check("t1_wrk_a0", wrk_a[W-1:0], 3);
        check("t1_wrk_c0", wrk_c[W-1:0], 5);
        while (!res_vld && (cyc - c0) < 40) @(negedge clk);
        check("t1_res_latency", cyc - c0, 7);
        check("t1_res_value", res, 26);
        @(negedge clk);
        check("t1_res_vld_after", res_vld, 0);
        check("t1_cp", dut.r_cp, 1);
        check("t1_dp", dut.r_dp, 1);

        // 20 back-to-back triplets, L=5, res_rdy=1
        do_reset();
        base = 0; clear_stats(20);
        for (int k = 0; k < 400 && n_out < n_tot; k++) step();
        arg_vld = 1'b0;
        check("t2_count", n_out, 20);
        check("t2_order", ord_err, 0);
        check("t2_first_stall", first_stall, 4);
        check("t2_stalls", stalls, 16);
        bad = 0;
        for (int i = 0; i < 16; i++) if (acc_cyc[i+4] - acc_cyc[i] != 8) bad++;
        check("t2_worker_period", bad, 0);
`ifdef SQRT_SCHED_STATS_EN
        check("t2_stall_cnt", stall_cnt, 16);
`endif

        // Out-of-order completion: latencies 9,3,3,3
        do_reset();
        lat[0] = 9; lat[1] = 3; lat[2] = 3; lat[3] = 3;
        base = 100; clear_stats(4); c0 = cyc;
        for (int k = 0; k < 60 && n_out < n_tot; k++) begin
            step();
            if (cyc - c0 == 9) begin
                check("t3_wait_res_vld", res_vld, 0);
                check("t3_w1_done", dut.r_state[1], 2);
                check("t3_w3_done", dut.r_state[3], 2);
            end
        end
        check("t3_count", n_out, 4);
        check("t3_order", ord_err, 0);
        check("t3_first_out", out_cyc[0] - c0, 11);
        check("t3_consecutive", out_cyc[3] - out_cyc[0], 3);
        for (int i = 0; i < N; i++) lat[i] = 5;

        // Consumer backpressure for 10 cycles
        do_reset();
        res_rdy = 1'b0;
        base = 200; clear_stats(5);
        for (int k = 0; k < 40 && !res_vld; k++) step();
        r0 = res;
        check("t4_first_val", r0, exp_of(0));
        unstable = 0; rdy_bad = 0;
        repeat (10) begin
            step();
            if (!res_vld || res !== r0) unstable++;
            if (arg_rdy) rdy_bad++;
        end
        check("t4_stable", unstable, 0);
        check("t4_arg_rdy_low", rdy_bad, 0);
        check("t4_no_out_yet", n_out, 0);
        res_rdy = 1'b1;
        for (int k = 0; k < 60 && n_out < n_tot; k++) step();
        check("t4_count", n_out, 5);
        check("t4_order", ord_err, 0);

        // Spurious return from an idle worker
        do_reset();
        spur = 4'b0100;
        @(negedge clk);
        spur = '0;
        check("t5_err_set", err, 1);
        check("t5_res_vld", res_vld, 0);
        check("t5_w2_idle", dut.r_state[2], 0);
        check("t5_arg_rdy", arg_rdy, 1);
        repeat (3) @(negedge clk);
        check("t5_err_sticky", err, 1);
        rst_n = 1'b0;
        #1;
        check("t5_err_cleared", err, 0);

        // Reset with three tasks in flight
        do_reset();
        base = 300; clear_stats(3);
        repeat (3) step();
        check("t6_pulse_before", wrk_arg_vld, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("t6_res_vld", res_vld, 0);
        check("t6_wrk_arg_vld", wrk_arg_vld, 0);
        check("t6_arg_rdy", arg_rdy, 1);
        arg_vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base = 400; clear_stats(1);
        for (int k = 0; k < 40 && n_out < n_tot; k++) step();
        check("t6_count", n_out, 1);
        check("t6_value", ord_err, 0);
        check("t6_from_w0", out_cp[0], 0);
        repeat (10) @(negedge clk);
        check("t6_no_extra", res_vld, 0);
        check("t6_no_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
